// File: rtl/output_row_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : output_row_writer_pkg
// Description : Shared lane width, FSM state encoding and lane-slice helper
//               for the output row writer.
// Revision    : 1.0 - initial release
// ============================================================================
package output_row_writer_pkg;

    // Bits per lane, signed two's complement
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // LSB position of a lane inside a packed row (lane 0 at the LSBs)
    function automatic int lane_lo(input int lane);
        return lane * DATA_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/output_row_writer_row_fifo.sv
`default_nettype none
// ============================================================================
// Module      : row_fifo
// Description : Generic synchronous FIFO. A push while full is accepted only
//               when a pop happens in the same cycle. The head is read
//               straight from registered storage and forced to zero when
//               the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module row_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one wrap bit so full and empty can be told apart
    always_comb begin
        empty     = (r_wr_ptr == r_rd_ptr);
        full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
        w_do_pop  = pop && !empty;
        w_do_push = push && (!full || w_do_pop);
        dout      = empty ? '0 : r_mem[r_rd_ptr[PTR_W-1:0]];
    end

    // Pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents are only visible through the pointers
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/output_row_writer.sv
`default_nettype none
// ============================================================================
// Module      : output_row_writer
// Description : Applies optional per-lane ReLU to serialized MAC rows,
//               generates the output-buffer address for each row and queues
//               it in a small FIFO drained over a valid/ready write port.
//               Rows arriving while the FIFO is full are dropped and flagged.
//               Lane width comes from the shared package.
// Revision    : 1.0 - initial release
// ============================================================================
module output_row_writer
    import output_row_writer_pkg::*;
#(
    parameter int POX        = 3,
    parameter int POY        = 3,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic [ADDR_W-1:0]     cfg_row_stride,
    input  logic [7:0]            cfg_num_tiles,
    input  logic                  relu_en,
    input  logic [POX*DATA_W-1:0] row_in,
    input  logic                  row_in_valid,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [POX*DATA_W-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int ROW_W   = POX * DATA_W;
    localparam int ENTRY_W = ADDR_W + ROW_W;
    localparam int RC_W    = (POY > 1) ? $clog2(POY) : 1;

    state_t             r_state;
    state_t             w_next_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_stride;
    logic [7:0]         r_num_tiles;
    logic [7:0]         r_tile_cnt;
    logic [RC_W-1:0]    r_row_cnt;
    logic               r_relu;
    logic               r_overflow;
    logic               r_zero_done;
    logic [ROW_W-1:0]   w_relu_row;
    logic [ENTRY_W-1:0] w_head;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_take;
    logic               w_pop;
    logic               w_drop;
    logic               w_last;

    // Per-lane ReLU on the incoming row
    for (genvar i = 0; i < POX; i++) begin : g_relu
        logic [DATA_W-1:0] w_lane;
        assign w_lane = row_in[lane_lo(i) +: DATA_W];
        assign w_relu_row[lane_lo(i) +: DATA_W] =
            (r_relu && w_lane[DATA_W-1]) ? '0 : w_lane;
    end

    // Row acceptance; a row is counted even when the FIFO must drop it
    always_comb begin
        w_take = (r_state == ST_RUN) && row_in_valid;
        w_pop  = wr_valid && wr_ready;
        w_drop = w_take && w_fifo_full && !w_pop;
        w_last = (r_tile_cnt == r_num_tiles - 8'd1) &&
                 (r_row_cnt == RC_W'(POY - 1));
    end

    row_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_take),
        .din   ({r_addr, w_relu_row}),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign wr_addr  = w_head[ENTRY_W-1 -: ADDR_W];
    assign wr_data  = w_head[ROW_W-1:0];
    assign overflow = r_overflow;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (cfg_start && (cfg_num_tiles != 8'd0)) w_next_state = ST_RUN;
            ST_RUN:   if (w_take && w_last)                     w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_fifo_empty)                         w_next_state = ST_IDLE;
            default:                                            w_next_state = ST_IDLE;
        endcase
    end

    // Status outputs; a zero-tile layer reports done from a registered flag
    always_comb begin
        busy     = (r_state != ST_IDLE);
        done     = r_zero_done || ((r_state == ST_DRAIN) && w_fifo_empty);
        wr_valid = !w_fifo_empty;
    end

    // Config latch, row/tile counters, running address and overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_stride    <= '0;
            r_num_tiles <= '0;
            r_tile_cnt  <= '0;
            r_row_cnt   <= '0;
            r_relu      <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= 1'b0;
            if ((r_state == ST_IDLE) && cfg_start) begin
                r_addr      <= cfg_base_addr;
                r_stride    <= cfg_row_stride;
                r_num_tiles <= cfg_num_tiles;
                r_relu      <= relu_en;
                r_overflow  <= 1'b0;
                r_tile_cnt  <= '0;
                r_row_cnt   <= '0;
                r_zero_done <= (cfg_num_tiles == 8'd0);
            end else if (w_take) begin
                r_addr <= r_addr + r_stride;
                if (r_row_cnt == RC_W'(POY - 1)) begin
                    r_row_cnt  <= '0;
                    r_tile_cnt <= r_tile_cnt + 8'd1;
                end else begin
                    r_row_cnt <= r_row_cnt + RC_W'(1);
                end
                if (w_drop) r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_output_row_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_row_writer
// Description : Self-checking bench for output_row_writer: a queue-based
//               model predicts every write, plus literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_row_writer;

    localparam int POX        = 3;
    localparam int POY        = 3;
    localparam int ADDR_W     = 12;
    localparam int FIFO_DEPTH = 4;
    localparam int DW         = 16;
    localparam int ROW_W      = POX * DW;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ROW_W-1:0]  data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_start = 1'b0;
    logic [ADDR_W-1:0] cfg_base_addr = '0;
    logic [ADDR_W-1:0] cfg_row_stride = '0;
    logic [7:0]        cfg_num_tiles = '0;
    logic              relu_en = 1'b0;
    logic [ROW_W-1:0]  row_in = '0;
    logic              row_in_valid = 1'b0;
    logic              wr_valid;
    logic              wr_ready = 1'b0;
    logic [ADDR_W-1:0] wr_addr;
    logic [ROW_W-1:0]  wr_data;
    logic              busy;
    logic              done;
    logic              overflow;

    output_row_writer #(
        .POX(POX), .POY(POY), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
        .cfg_base_addr(cfg_base_addr), .cfg_row_stride(cfg_row_stride),
        .cfg_num_tiles(cfg_num_tiles), .relu_en(relu_en),
        .row_in(row_in), .row_in_valid(row_in_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int  tests = 0;
    int  fails = 0;
    int  done_cnt = 0;
    wr_t mq[$];     // model: rows expected on the write port, in order
    wr_t wlog[$];   // writes actually handshaken by the DUT

    // model state
    bit                m_busy = 0, m_drain = 0, m_ovf = 0, m_zdone = 0;
    bit                m_pop, m_zd;
    int                m_idx = 0, m_total = 0;
    logic [ADDR_W-1:0] m_base = '0, m_stride = '0;
    bit                m_relu = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ROW_W-1:0] mkrow(input int l0, input int l1, input int l2);
        return {16'(l2), 16'(l1), 16'(l0)};
    endfunction

    function automatic logic [ROW_W-1:0] relu_row(input logic [ROW_W-1:0] r, input bit en);
        logic [ROW_W-1:0] o;
        o = r;
        for (int i = 0; i < POX; i++)
            if (en && ($signed(r[i*DW +: DW]) < 0)) o[i*DW +: DW] = '0;
        return o;
    endfunction

    // Behavioural model: row k of a layer goes to base + k*stride
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_busy = 0; m_drain = 0; m_ovf = 0; m_zdone = 0;
        end else begin
            m_pop = (mq.size() > 0) && wr_ready;
            m_zd  = 0;
            if (!m_busy) begin
                if (cfg_start) begin
                    m_base = cfg_base_addr; m_stride = cfg_row_stride;
                    m_relu = relu_en; m_ovf = 0; m_idx = 0;
                    m_total = int'(cfg_num_tiles) * POY;
                    if (cfg_num_tiles == 8'd0) m_zd = 1;
                    else m_busy = 1;
                end
            end else if (!m_drain) begin
                if (row_in_valid) begin
                    if (mq.size() < FIFO_DEPTH || m_pop)
                        mq.push_back({ADDR_W'(int'(m_base) + m_idx * int'(m_stride)),
                                      relu_row(row_in, m_relu)});
                    else
                        m_ovf = 1;
                    m_idx++;
                    if (m_idx == m_total) m_drain = 1;
                end
            end else if (mq.size() == 0) begin
                m_busy = 0; m_drain = 0;
            end
            if (m_pop) void'(mq.pop_front());
            m_zdone = m_zd;
        end
    end

    // Compare DUT against the model every cycle, mid-cycle
    initial forever begin
        @(negedge clk);
        check("wr_valid", wr_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            check("wr_addr", wr_addr, mq[0].addr);
            check("wr_data", wr_data, mq[0].data);
        end
        if (wr_valid && wr_ready) wlog.push_back({wr_addr, wr_data});
        check("busy", busy, m_busy);
        check("done", done, m_zdone || (m_drain && mq.size() == 0));
        check("overflow", overflow, m_ovf);
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride,
                         input logic [7:0] tiles, input bit relu);
        cfg_base_addr = base; cfg_row_stride = stride;
        cfg_num_tiles = tiles; relu_en = relu; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send(input logic [ROW_W-1:0] r, input bit toggle_ready);
        row_in = r; row_in_valid = 1'b1;
        if (toggle_ready) wr_ready = ~wr_ready;
        tick();
        row_in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, input bit toggle);
        bit seen;
        int n;
        seen = 0; n = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
            tick();
            n++;
            if (toggle) wr_ready = ~wr_ready;
        end
        check(name, seen, 1'b1);
        wr_ready = 1'b1;
        tick(); tick();
    endtask

    task automatic basic_layer(input bit relu);
        wlog.delete();
        wr_ready = 1'b1;
        start(12'h010, 12'd2, 8'd1, relu);
        send(mkrow(-5, 7, 0), 0);
        send(mkrow(1, -1, 2), 0);
        send(mkrow(3, 4, -8), 0);
        wait_done("basic_done", 50, 0);
    endtask

    int d0;

    initial begin
        // reset state
        repeat (2) tick();
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_wr_addr", wr_addr, '0);
        check("rst_wr_data", wr_data, '0);
        rst_n = 1'b1;
        tick();

        // 1: ReLU on, three rows, one tile
        d0 = done_cnt;
        basic_layer(1'b1);
        check("t1_done_pulses", done_cnt - d0, 1);
        check("t1_nwrites", wlog.size(), 3);
        if (wlog.size() == 3) begin
            check("t1_addr0", wlog[0].addr, 12'h010);
            check("t1_addr1", wlog[1].addr, 12'h012);
            check("t1_addr2", wlog[2].addr, 12'h014);
            check("t1_data0", wlog[0].data, 48'h0000_0007_0000);
            check("t1_data1", wlog[1].data, 48'h0002_0000_0001);
            check("t1_data2", wlog[2].data, 48'h0000_0004_0003);
        end
        check("t1_overflow", overflow, 1'b0);

        // 2: ReLU off, raw data passes
        basic_layer(1'b0);
        check("t2_nwrites", wlog.size(), 3);
        if (wlog.size() == 3) begin
            check("t2_lane0", wlog[0].data[15:0], 16'hFFFB);
            check("t2_data1", wlog[1].data, 48'h0002_FFFF_0001);
        end

        // 3: stalled sink, six rows into a four-deep FIFO
        wlog.delete();
        wr_ready = 1'b0;
        start(12'h100, 12'd1, 8'd2, 1'b0);
        for (int i = 0; i < 6; i++) send(mkrow(i, i + 10, i + 20), 0);
        tick(); tick();
        check("t3_overflow_set", overflow, 1'b1);
        wr_ready = 1'b1;
        wait_done("t3_done", 50, 0);
        check("t3_nwrites", wlog.size(), 4);
        if (wlog.size() == 4) begin
            check("t3_addr0", wlog[0].addr, 12'h100);
            check("t3_addr3", wlog[3].addr, 12'h103);
            check("t3_data3", wlog[3].data, 48'h0017_000D_0003);
        end
        check("t3_overflow_sticky", overflow, 1'b1);

        // 4: wr_ready toggling every cycle
        wlog.delete();
        wr_ready = 1'b0;
        start(12'h020, 12'd4, 8'd1, 1'b0);
        send(mkrow(11, 12, 13), 1);
        send(mkrow(21, 22, 23), 1);
        send(mkrow(31, 32, 33), 1);
        wait_done("t4_done", 50, 1);
        check("t4_nwrites", wlog.size(), 3);
        if (wlog.size() == 3) begin
            check("t4_addr2", wlog[2].addr, 12'h028);
            check("t4_data2", wlog[2].data, 48'h0021_0020_001F);
        end
        check("t4_overflow_cleared", overflow, 1'b0);

        // 5: address wrap
        wlog.delete();
        start(12'hFFE, 12'd1, 8'd1, 1'b0);
        for (int i = 0; i < 3; i++) send(mkrow(i, i, i), 0);
        wait_done("t5_done", 50, 0);
        check("t5_nwrites", wlog.size(), 3);
        if (wlog.size() == 3) begin
            check("t5_addr0", wlog[0].addr, 12'hFFE);
            check("t5_addr1", wlog[1].addr, 12'hFFF);
            check("t5_addr2", wlog[2].addr, 12'h000);
        end

        // 6: zero tiles
        wlog.delete();
        start(12'h050, 12'd1, 8'd0, 1'b0);
        @(negedge clk);
        check("t6_done_next", done, 1'b1);
        check("t6_busy", busy, 1'b0);
        @(negedge clk);
        check("t6_done_once", done, 1'b0);
        tick();
        check("t6_nwrites", wlog.size(), 0);

        // 7: reset mid-run, then a clean layer
        wr_ready = 1'b0;
        start(12'h200, 12'd1, 8'd2, 1'b0);
        send(mkrow(1, 2, 3), 0);
        send(mkrow(4, 5, 6), 0);
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_wr_valid", wr_valid, 1'b0);
        check("t7_rst_busy", busy, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        basic_layer(1'b1);
        check("t7_nwrites", wlog.size(), 3);
        if (wlog.size() == 3) check("t7_data0", wlog[0].data, 48'h0000_0007_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
